// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall vectors, FSM states
// and exception type codes.
package pipeline_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bit order: {WB, MEM, EX, ID, IF, PC}
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] EXC_NONE     = 32'h0000_0000;
  localparam logic [31:0] EXC_INT      = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL  = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INV = 32'h0000_000a;
  localparam logic [31:0] EXC_TRAP     = 32'h0000_000d;
  localparam logic [31:0] EXC_OV       = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stall/flush handshake between the pipeline stages and pipeline_ctrl.
interface pipeline_ctrl_if;

  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc
  );

endinterface

// File: rtl/pipeline_ctrl_stall_wdt.sv
// Stall watchdog: saturating count of consecutive stalled cycles and a
// sticky timeout flag that only reset clears.
module ctrl_stall_wdt #(
  parameter int unsigned MAX_STALL = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stalling,
  output logic timeout
);

  logic [7:0] cnt_q;
  logic       timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!stalling) begin
        cnt_q <= '0;
      end else if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (stalling && (cnt_q == 8'(MAX_STALL - 1))) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stall arbitration, exception/ERET flush sequencing
// and stall watchdog. Optional perf counters under `CTRL_PERF_CNT_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
  parameter int unsigned MAX_STALL  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_ctrl_if.slave       bus,
  output logic                 stall_timeout,
  output logic [1:0]           state_o,
  output logic [31:0]          stall_cycles_o,
  output logic [31:0]          flush_count_o
);

  ctrl_state_e state_q;
  logic [5:0]  stall_d;
  logic        flush_d;
  logic [31:0] new_pc_d;
  logic        exc;
  logic        any_req;

  assign exc     = (bus.excepttype_i != EXC_NONE);
  assign any_req = bus.stallreq_from_id | bus.stallreq_from_ex | bus.stallreq_from_mem;

  // Requests seen during S_FLUSH belong to squashed instructions.
  always_comb begin
    stall_d  = STALL_NONE;
    flush_d  = 1'b0;
    new_pc_d = '0;
    if (!rst) begin
      if (exc) begin
        flush_d  = 1'b1;
        new_pc_d = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
      end else if (state_q != S_FLUSH) begin
        if (bus.stallreq_from_mem) begin
          stall_d = STALL_MEM;
        end else if (bus.stallreq_from_ex) begin
          stall_d = STALL_EX;
        end else if (bus.stallreq_from_id) begin
          stall_d = STALL_ID;
        end
      end
    end
  end

  assign bus.stall  = stall_d;
  assign bus.flush  = flush_d;
  assign bus.new_pc = new_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
    end else if (exc) begin
      state_q <= S_FLUSH;
    end else begin
      case (state_q)
        S_RUN:   state_q <= any_req ? S_STALL : S_RUN;
        S_STALL: state_q <= any_req ? S_STALL : S_RUN;
        S_FLUSH: state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign state_o = state_q;

  ctrl_stall_wdt #(
    .MAX_STALL(MAX_STALL)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .stalling (|stall_d),
    .timeout  (stall_timeout)
  );

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (|stall_d) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_d)  flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_timeout;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .EXC_VECTOR(32'h0000_0020),
    .ERET_CODE (32'h0000_000e),
    .MAX_STALL (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .stall_timeout  (stall_timeout),
    .state_o        (state_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic [31:0] et, input logic [31:0] epc);
    bus.stallreq_from_id  = id;
    bus.stallreq_from_ex  = ex;
    bus.stallreq_from_mem = mem;
    bus.excepttype_i      = et;
    bus.cp0_epc_i         = epc;
    #2;
  endtask

  // Advance one clock edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] st, input logic fl,
                         input logic [31:0] pc);
    check({tag, ".stall"},  {26'd0, bus.stall}, {26'd0, st});
    check({tag, ".flush"},  {31'd0, bus.flush}, {31'd0, fl});
    check({tag, ".new_pc"}, bus.new_pc, pc);
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 32'h1, 32'h5555_0000);
    rst = 1'b1;
    chk_out("reset", 6'b000000, 1'b0, 32'h0);
    tick();
    check("reset.state", {30'd0, state_o}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("reset.state_rel", {30'd0, state_o}, 32'd0);
    check("reset.timeout", {31'd0, stall_timeout}, 32'd0);
    chk_out("idle", 6'b000000, 1'b0, 32'h0);

    // ID+EX together: EX wins
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      check("prio.idex.stall", {26'd0, bus.stall}, 32'h0000_000f);
      tick();
      check("prio.idex.state", {30'd0, state_o}, 32'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
    check("prio.mem.stall", {26'd0, bus.stall}, 32'h0000_001f);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("prio.id.stall", {26'd0, bus.stall}, 32'h0000_0007);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_out("prio.drop", 6'b000000, 1'b0, 32'h0);
    check("prio.drop.state", {30'd0, state_o}, 32'd1);
    tick();
    check("prio.run.state", {30'd0, state_o}, 32'd0);

    // Exception overriding an EX stall
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_1234);
    chk_out("exc", 6'b000000, 1'b1, 32'h0000_0020);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_1234);
    check("exc.flush_state", {30'd0, state_o}, 32'd2);
    chk_out("exc.squash", 6'b000000, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("exc.back_run", {30'd0, state_o}, 32'd0);
    tick();

    // ERET then back-to-back exception
    drive(1'b0, 1'b0, 1'b1, 32'h0000_000e, 32'h0000_1234);
    chk_out("eret", 6'b000000, 1'b1, 32'h0000_1234);
    tick();
    check("eret.state", {30'd0, state_o}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0000_000a, 32'h0000_1234);
    chk_out("b2b", 6'b000000, 1'b1, 32'h0000_0020);
    tick();
    check("b2b.state", {30'd0, state_o}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("b2b.run", {30'd0, state_o}, 32'd0);

    // Watchdog boundary: 63 stalled cycles must not trip it
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 63; i++) tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("wdt.63", {31'd0, stall_timeout}, 32'd0);

    // 64 consecutive stalled cycles trip it on the 64th edge
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) check("wdt.pre64", {31'd0, stall_timeout}, 32'd0);
      tick();
    end
    check("wdt.64", {31'd0, stall_timeout}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_out("wdt.no_side_effect", 6'b000000, 1'b0, 32'h0);
    tick();
    tick();
    check("wdt.sticky", {31'd0, stall_timeout}, 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("wdt.cleared", {31'd0, stall_timeout}, 32'd0);
    check("perf.rst.stall", stall_cycles_o, 32'd0);
    check("perf.rst.flush", flush_count_o, 32'd0);

    // 10 stalled cycles and 2 flushes
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0000_000c, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
`ifdef CTRL_PERF_CNT_EN
    check("perf.stall_cycles", stall_cycles_o, 32'd10);
    check("perf.flush_count", flush_count_o, 32'd2);
`else
    check("perf.stall_cycles", stall_cycles_o, 32'd0);
    check("perf.flush_count", flush_count_o, 32'd0);
`endif
    check("perf.state", {30'd0, state_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline controller for the 5-stage core. It arbitrates stall requests from ID, EX and MEM, and drives the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It also sequences exception/ERET flushes, supplying the redirect PC to pc_reg. A stall watchdog flags a pipeline that stays frozen too long.

Parameters:
EXC_VECTOR, 32'h00000020, redirect PC for all exceptions except ERET
ERET_CODE, 32'h0000000e, excepttype value meaning ERET (redirect to EPC)
MAX_STALL, 64, consecutive stalled cycles before stall_timeout sets (range 2..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high (1 = `RstEnable)
stallreq_from_id  input  1  ID needs an operand (load-use)
stallreq_from_ex  input  1  EX multi-cycle op busy (div/madd)
stallreq_from_mem  input  1  MEM waiting on data bus
excepttype_i  input  32  from MEM; nonzero = exception/ERET this cycle
cp0_epc_i  input  32  current EPC from CP0
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop
flush  output  1  clear all pipeline registers this cycle
new_pc  output  32  redirect target, valid when flush=1
stall_timeout  output  1  sticky watchdog error
state_o  output  2  current FSM state (debug)
stall_cycles_o  output  32  performance counter (see Optional Feature)
flush_count_o  output  32  performance counter (see Optional Feature)

Behaviour:
- stall, flush and new_pc are combinational from the current inputs and state. Pipeline registers sample them at the same edge, so the response has zero-cycle latency.
- Priority: exception > MEM > EX > ID.
- Exception (excepttype_i != 0) in any state:
  - flush=1 and stall=6'b000000.
  - new_pc = cp0_epc_i if excepttype_i == ERET_CODE, else EXC_VECTOR.
  - Next state is S_FLUSH.
- Stall vectors when there is no exception:
  - MEM request: 6'b011111.
  - EX request: 6'b001111.
  - ID request: 6'b000111.
  - No request: 6'b000000.
- Outside a flush, flush=0 and new_pc=32'h0.
- FSM states: S_RUN=2'd0, S_STALL=2'd1, S_FLUSH=2'd2.
  - S_RUN: any request goes to S_STALL; otherwise stay in S_RUN.
  - S_STALL: stay while any request is high; all requests low goes to S_RUN.
  - S_FLUSH lasts exactly one cycle. In it, stall requests are ignored (stall=0), because they come from squashed instructions. Next state is S_RUN.
  - An exception arriving during S_FLUSH flushes again and the FSM remains in S_FLUSH.
  - An exception arriving during S_STALL overrides the stall in that same cycle.
- Watchdog:
  - An 8-bit counter increments each cycle the stall output is nonzero, saturating at 255.
  - The counter clears on any cycle with stall=0.
  - When the counter equals MAX_STALL-1 while stalling, stall_timeout sets on the next edge.
  - stall_timeout stays set until reset; it never stalls or flushes the pipeline itself.
- Reset (rst=1 at an edge): state becomes S_RUN, the watchdog counter becomes 0 and stall_timeout becomes 0.
- While rst=1, stall, flush and new_pc are forced to 0 regardless of inputs.
- A reset during a stall or flush abandons the operation with no residual effect.

Optional Feature:
CTRL_PERF_CNT_EN
- Defined:
  - stall_cycles_o increments each cycle stall != 0.
  - flush_count_o increments each cycle flush=1.
  - Both are 32-bit, wrap from 32'hFFFFFFFF to 0, and reset to 0.
- Undefined: both ports remain present, are tied to 32'h0, and no counter flops are built.

Decomposition:
- defines.v holds:
  - `Stop/`NoStop.
  - The stall vector constants: STALL_NONE, STALL_ID, STALL_EX, STALL_MEM.
  - The FSM state encodings.
  - The excepttype codes, including ERET.
- One sub-module is natural: ctrl_stall_wdt.
  - Inputs: clk, rst, stalling.
  - Output: timeout.
  - Holds the saturating counter and sticky flag, parameterised by MAX_STALL.

Test Plan:
- Reset: rst=1 with all requests=1 and excepttype=32'h1 -> stall=0, flush=0, new_pc=0, state_o=0; after release, stall_timeout=0.
- Priority: id=1, ex=1 for 3 cycles -> stall=6'b001111 each cycle, state_o=1. Then mem=1 -> 6'b011111. All requests dropped -> stall=0, state_o returns to 0 next cycle.
- Exception during a stall: ex=1, then excepttype=32'h00000008 -> same cycle flush=1, stall=0, new_pc=32'h20. Next cycle state_o=2 with ex still 1 -> stall=0. The cycle after, state_o=0.
- ERET: excepttype=32'h0000000e, cp0_epc_i=32'h0000_1234 -> flush=1, new_pc=32'h0000_1234. Back-to-back exceptions -> flush=1 on both cycles, state_o stays 2.
- Watchdog: mem=1 held with MAX_STALL=64 -> stall_timeout=0 through 63 stalled cycles, 1 after the 64th. It stays 1 after the request drops, and only rst clears it.
- Perf counters with CTRL_PERF_CNT_EN: 10 stall cycles plus 2 flushes -> stall_cycles_o=10, flush_count_o=2. A forced counter preload of 32'hFFFFFFFF followed by one stall -> 0.
